// File: rtl/tone_generator.sv
// rtl/tone_generator.sv - square-wave speaker drive from a half-period note code
// Tick length scales with the octave select so a single note table spans four octaves.
module tone_generator #(
  parameter int PRESCALE = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] note,
  input  logic [1:0] octave,
  output logic       spk,
  output logic       active,
  output logic       toggle
);

  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] pres;
  logic [5:0]    hcnt;
  logic [5:0]    note_q;
  logic [31:0]   tick_max;
  logic [PW-1:0] tick_last;
  logic          tick;
  logic          half_done;
  logic          note_change;
  logic          idle;

  // Octave changes act immediately; the >= compare keeps a shortened tick from overrunning.
  assign tick_max    = 32'(PRESCALE) >> octave;
  assign tick_last   = PW'(tick_max - 32'd1);
  assign tick        = (pres >= tick_last);
  assign half_done   = (hcnt == (note_q - 6'd1));
  assign note_change = (note != note_q);
  assign idle        = (note_q == 6'd0) || !en;

  always_ff @(posedge clk) begin
    if (rst) begin
      spk    <= 1'b0;
      active <= 1'b0;
      toggle <= 1'b0;
      pres   <= '0;
      hcnt   <= '0;
      note_q <= '0;
    end else if (note_change) begin
      note_q <= note;
      pres   <= '0;
      hcnt   <= '0;
      spk    <= 1'b0;
      toggle <= 1'b0;
      active <= en && (note != 6'd0);
    end else if (idle) begin
      spk    <= 1'b0;
      toggle <= 1'b0;
      active <= 1'b0;
      pres   <= '0;
      hcnt   <= '0;
    end else begin
      active <= 1'b1;
      if (tick) begin
        pres <= '0;
        if (half_done) begin
          hcnt   <= '0;
          spk    <= ~spk;
          toggle <= 1'b1;
        end else begin
          hcnt   <= hcnt + 6'd1;
          toggle <= 1'b0;
        end
      end else begin
        pres   <= pres + PW'(1);
        toggle <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tone_generator.sv
// tb/tb_tone_generator.sv - directed and randomized checks of tone_generator
// Reference model counts ticks since phase start and derives spk/toggle arithmetically.
module tb_tone_generator;

  localparam int P = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [5:0] note = 6'd30;
  logic [1:0] octave = 2'd0;
  logic       spk, active, toggle;

  int n_checks = 0;
  int n_fail = 0;

  int         m_note_q = 0;
  int         m_pres = 0;
  int         m_ticks = 0;
  logic       m_spk = 1'b0;
  logic       m_active = 1'b0;
  logic       m_toggle = 1'b0;

  tone_generator #(.PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .en(en), .note(note), .octave(octave),
    .spk(spk), .active(active), .toggle(toggle)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    int tm;
    tm = P >> octave;
    if (rst) begin
      m_note_q = 0; m_pres = 0; m_ticks = 0;
      m_spk = 0; m_active = 0; m_toggle = 0;
    end else if (int'(note) != m_note_q) begin
      m_note_q = int'(note); m_pres = 0; m_ticks = 0;
      m_spk = 0; m_toggle = 0;
      m_active = en && (note != 0);
    end else if (m_note_q == 0 || !en) begin
      m_pres = 0; m_ticks = 0;
      m_spk = 0; m_toggle = 0; m_active = 0;
    end else begin
      m_active = 1;
      if (m_pres + 1 >= tm) begin
        m_pres = 0;
        m_ticks++;
        m_toggle = (m_ticks % m_note_q) == 0;
        m_spk = ((m_ticks / m_note_q) % 2) == 1;
      end else begin
        m_pres++;
        m_toggle = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic wait_toggle(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (toggle === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; en = 1; note = 6'd30;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({spk, active, toggle} !== 3'b000) begin
        n_fail++; $display("FAIL reset_hold cycle %0d: got %b want 000", i, {spk, active, toggle});
      end
    end
    rst = 0;
    step();
    n_checks++;
    if ({spk, active, toggle} !== 3'b010) begin
      n_fail++; $display("FAIL reset_capture: got %b want 010", {spk, active, toggle});
    end
  endtask

  task automatic test_basic();
    int n;
    octave = 0; note = 0; step();
    note = 3; step();
    n_checks++;
    if ({spk, active} !== 2'b01) begin
      n_fail++; $display("FAIL basic_capture: got spk/active %b want 01", {spk, active});
    end
    wait_toggle(100, n);
    n_checks++;
    if (n !== 24 || spk !== 1'b1) begin
      n_fail++; $display("FAIL basic_first_rise: got %0d edges spk=%b want 24 spk=1", n, spk);
    end
    step();
    n_checks++;
    if (toggle !== 1'b0) begin
      n_fail++; $display("FAIL basic_pulse_width: got toggle=%b want 0", toggle);
    end
    wait_toggle(100, n);
    n_checks++;
    if (n !== 23 || spk !== 1'b0) begin
      n_fail++; $display("FAIL basic_fall: got %0d edges spk=%b want 23 spk=0", n, spk);
    end
    wait_toggle(100, n);
    n_checks++;
    if (n !== 24 || spk !== 1'b1) begin
      n_fail++; $display("FAIL basic_period: got %0d edges spk=%b want 24 spk=1", n, spk);
    end
  endtask

  task automatic test_octave();
    int n;
    octave = 0; note = 0; step();
    note = 3; step();
    for (int i = 0; i < 5; i++) step();
    octave = 3;
    wait_toggle(100, n);
    n_checks++;
    if (n !== 3) begin
      n_fail++; $display("FAIL octave_switch_midtick: got %0d edges want 3", n);
    end
    wait_toggle(100, n);
    n_checks++;
    if (n !== 3) begin
      n_fail++; $display("FAIL octave3_half: got %0d edges want 3", n);
    end
    octave = 1;
    wait_toggle(100, n);
    n_checks++;
    if (n !== 12) begin
      n_fail++; $display("FAIL octave1_half: got %0d edges want 12", n);
    end
    octave = 0;
  endtask

  task automatic test_note_change();
    int n;
    int pulses;
    note = 0; step();
    note = 3; step();
    wait_toggle(100, n);
    for (int i = 0; i < 10; i++) step();
    note = 5; step();
    n_checks++;
    if ({spk, active, toggle} !== 3'b010) begin
      n_fail++; $display("FAIL note_change_capture: got %b want 010", {spk, active, toggle});
    end
    wait_toggle(100, n);
    n_checks++;
    if (n !== 40 || spk !== 1'b1) begin
      n_fail++; $display("FAIL note_change_rise: got %0d edges spk=%b want 40 spk=1", n, spk);
    end
    note = 0; step();
    n_checks++;
    if ({spk, active} !== 2'b00) begin
      n_fail++; $display("FAIL note_off: got spk/active %b want 00", {spk, active});
    end
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (toggle !== 1'b0 || spk !== 1'b0) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL silence_after_off: got %0d active cycles want 0", pulses);
    end
  endtask

  task automatic test_enable();
    int n;
    note = 2; step();
    wait_toggle(100, n);
    for (int i = 0; i < 4; i++) step();
    en = 0; step();
    n_checks++;
    if ({spk, active} !== 2'b00) begin
      n_fail++; $display("FAIL en_drop: got spk/active %b want 00", {spk, active});
    end
    en = 1;
    wait_toggle(100, n);
    n_checks++;
    if (n !== 16 || spk !== 1'b1) begin
      n_fail++; $display("FAIL en_restore_rise: got %0d edges spk=%b want 16 spk=1", n, spk);
    end
    en = 0; note = 3; step();
    n_checks++;
    if ({spk, active} !== 2'b00) begin
      n_fail++; $display("FAIL note_change_en_low: got spk/active %b want 00", {spk, active});
    end
    step();
    n_checks++;
    if ({spk, active} !== 2'b00) begin
      n_fail++; $display("FAIL idle_after_en_low: got spk/active %b want 00", {spk, active});
    end
    en = 1;
  endtask

  task automatic test_reset_mid();
    int n;
    wait_toggle(100, n);
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (spk !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_setup: got spk=%b want 1", spk);
    end
    rst = 1; step();
    n_checks++;
    if ({spk, active, toggle} !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid: got %b want 000", {spk, active, toggle});
    end
    rst = 0; step();
    n_checks++;
    if ({spk, active} !== 2'b01) begin
      n_fail++; $display("FAIL reset_mid_recapture: got spk/active %b want 01", {spk, active});
    end
    wait_toggle(100, n);
    n_checks++;
    if (n !== 24) begin
      n_fail++; $display("FAIL reset_mid_restart: got %0d edges want 24", n);
    end
  endtask

  task automatic test_model_sync();
    n_checks++;
    if ({spk, active, toggle} !== {m_spk, m_active, m_toggle}) begin
      n_fail++; $display("FAIL model_sync: got %b want %b", {spk, active, toggle}, {m_spk, m_active, m_toggle});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) note = 6'($urandom_range(0, 9));
      if ($urandom_range(0, 199) < 1) note = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 99) < 2) octave = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 2) en = ~en;
      rst = ($urandom_range(0, 499) == 0);
      step();
      n_checks++;
      if ({spk, active, toggle} !== {m_spk, m_active, m_toggle}) begin
        n_fail++;
        $display("FAIL random cycle %0d: got spk/active/toggle %b want %b", i,
                 {spk, active, toggle}, {m_spk, m_active, m_toggle});
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_model_sync();
    test_basic();
    test_model_sync();
    test_octave();
    test_model_sync();
    test_note_change();
    test_model_sync();
    test_enable();
    test_model_sync();
    test_reset_mid();
    test_model_sync();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
